// File: rtl/md_scheduler_if.sv
// Issue/result bundle between the E stage, D-stage hazard logic and the
// multiply/divide scheduler.
interface md_scheduler_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MdUseD;
    logic        Busy;
    logic        StallMD;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, MdUseD,
        input  Busy, StallMD, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, MdUseD,
        output Busy, StallMD, Hi, Lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div scheduler: the result is computed at issue, held in
// shadow registers and committed to HI/LO after a fixed busy window.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    md_scheduler_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] his_q, his_d;
    logic [31:0] los_q, los_d;
    logic        wr_q, wr_d;

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] divs_quot_s, divs_rem_s;
    logic [31:0] divu_quot_s, divu_rem_s;
    logic        b_zero_s;
    logic        busy_s;

    // Result datapath: all four candidate results from the forwarded operands.
    always_comb begin
        prod_signed_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_unsigned_s = {32'd0, bus.A} * {32'd0, bus.B};
        b_zero_s        = (bus.B == 32'd0);
        divs_quot_s     = 32'd0;
        divs_rem_s      = 32'd0;
        divu_quot_s     = 32'd0;
        divu_rem_s      = 32'd0;
        // Guarded so a zero divisor never feeds the dividers.
        if (!b_zero_s) begin
            divs_quot_s = $signed(bus.A) / $signed(bus.B);
            divs_rem_s  = $signed(bus.A) % $signed(bus.B);
            divu_quot_s = bus.A / bus.B;
            divu_rem_s  = bus.A % bus.B;
        end else begin
            divs_quot_s = 32'd0;
            divs_rem_s  = 32'd0;
            divu_quot_s = 32'd0;
            divu_rem_s  = 32'd0;
        end
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        his_d   = his_q;
        los_d   = los_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        3'd0: begin
                            his_d   = prod_signed_s[63:32];
                            los_d   = prod_signed_s[31:0];
                            wr_d    = 1'b1;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_RUN;
                        end
                        3'd1: begin
                            his_d   = prod_unsigned_s[63:32];
                            los_d   = prod_unsigned_s[31:0];
                            wr_d    = 1'b1;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_RUN;
                        end
                        3'd2: begin
                            his_d   = divs_rem_s;
                            los_d   = divs_quot_s;
                            wr_d    = ~b_zero_s;
                            cnt_d   = DIV_LOAD;
                            state_d = ST_RUN;
                        end
                        3'd3: begin
                            his_d   = divu_rem_s;
                            los_d   = divu_quot_s;
                            wr_d    = ~b_zero_s;
                            cnt_d   = DIV_LOAD;
                            state_d = ST_RUN;
                        end
                        3'd4: hi_d = bus.A;
                        3'd5: lo_d = bus.A;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A divide by zero still burns its window but never commits.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = his_q;
                        lo_d = los_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and result registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            his_q   <= 32'd0;
            los_q   <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            his_q   <= his_d;
            los_q   <= los_d;
            wr_q    <= wr_d;
        end
    end

    assign busy_s      = (state_q == ST_RUN);
    assign bus.Busy    = busy_s;
    assign bus.StallMD = bus.MdUseD & (busy_s | bus.Start) & ~Reset;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: mult/div latency and results, mthi/mtlo,
// StallMD window and asynchronous reset mid-operation.
module tb_md_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n_busy;
    int   n_stall;

    md_scheduler_if bus ();

    md_scheduler #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; Start is high for exactly one rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        check_val("no_start_in_run", {63'd0, bus.Busy}, 64'd0);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    // Counts busy negedges; ends at the first idle negedge (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.Start  = 1'b1;
        bus.Op     = 3'd4;
        bus.A      = 32'hDEAD_BEEF;
        bus.B      = 32'd0;
        bus.MdUseD = 1'b1;
        #1;
        check_val("rst_stall", {63'd0, bus.StallMD}, 64'd0);
        repeat (3) @(negedge clk);
        check_val("rst_busy", {63'd0, bus.Busy}, 64'd0);
        check_val("rst_hi", {32'd0, bus.Hi}, 64'd0);
        check_val("rst_lo", {32'd0, bus.Lo}, 64'd0);
        check_val("rst_stall2", {63'd0, bus.StallMD}, 64'd0);
        bus.Start  = 1'b0;
        bus.MdUseD = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        count_busy(n_busy);
        check_val("mult_busy", 64'(n_busy), 64'd5);
        check_val("mult_hi", {32'd0, bus.Hi}, 64'h0000_0000_FFFF_FFFF);
        check_val("mult_lo", {32'd0, bus.Lo}, 64'h0000_0000_FFFF_FFFE);

        // Back-to-back issue in the first idle cycle.
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n_busy);
        check_val("multu_busy", 64'(n_busy), 64'd5);
        check_val("multu_hi", {32'd0, bus.Hi}, 64'h0000_0000_0000_0001);
        check_val("multu_lo", {32'd0, bus.Lo}, 64'h0000_0000_FFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        count_busy(n_busy);
        check_val("div_busy", 64'(n_busy), 64'd10);
        check_val("div_lo", {32'd0, bus.Lo}, 64'h0000_0000_FFFF_FFFD);
        check_val("div_hi", {32'd0, bus.Hi}, 64'h0000_0000_FFFF_FFFF);

        issue(3'd3, 32'd55, 32'd0);
        count_busy(n_busy);
        check_val("divu0_busy", 64'(n_busy), 64'd10);
        check_val("divu0_hi", {32'd0, bus.Hi}, 64'h0000_0000_FFFF_FFFF);
        check_val("divu0_lo", {32'd0, bus.Lo}, 64'h0000_0000_FFFF_FFFD);

        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        count_busy(n_busy);
        check_val("div_neg_b_lo", {32'd0, bus.Lo}, 64'h0000_0000_FFFF_FFFD);
        check_val("div_neg_b_hi", {32'd0, bus.Hi}, 64'h0000_0000_0000_0001);

        issue(3'd3, 32'd100, 32'd7);
        count_busy(n_busy);
        check_val("divu_lo", {32'd0, bus.Lo}, 64'd14);
        check_val("divu_hi", {32'd0, bus.Hi}, 64'd2);

        issue(3'd4, 32'h1234_5678, 32'd0);
        check_val("mthi_hi", {32'd0, bus.Hi}, 64'h0000_0000_1234_5678);
        check_val("mthi_busy", {63'd0, bus.Busy}, 64'd0);
        check_val("mthi_lo", {32'd0, bus.Lo}, 64'd14);

        issue(3'd5, 32'hCAFE_BABE, 32'd0);
        check_val("mtlo_lo", {32'd0, bus.Lo}, 64'h0000_0000_CAFE_BABE);
        check_val("mtlo_busy", {63'd0, bus.Busy}, 64'd0);

        issue(3'd6, 32'h5555_5555, 32'd3);
        check_val("nop_busy", {63'd0, bus.Busy}, 64'd0);
        check_val("nop_hi", {32'd0, bus.Hi}, 64'h0000_0000_1234_5678);
        check_val("nop_lo", {32'd0, bus.Lo}, 64'h0000_0000_CAFE_BABE);

        // StallMD window: Start cycle plus five busy cycles.
        n_stall    = 0;
        bus.MdUseD = 1'b1;
        bus.Start  = 1'b1;
        bus.Op     = 3'd1;
        bus.A      = 32'd3;
        bus.B      = 32'd4;
        #1;
        if (bus.StallMD) n_stall++;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.StallMD) n_stall++;
            @(negedge clk);
        end
        check_val("stall_cycles", 64'(n_stall), 64'd6);
        check_val("stall_end", {63'd0, bus.StallMD}, 64'd0);
        check_val("stall_mul_lo", {32'd0, bus.Lo}, 64'd12);
        bus.MdUseD = 1'b0;

        // Asynchronous reset in the third cycle of a divide.
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check_val("pre_rst_busy", {63'd0, bus.Busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_busy", {63'd0, bus.Busy}, 64'd0);
        check_val("async_hi", {32'd0, bus.Hi}, 64'd0);
        check_val("async_lo", {32'd0, bus.Lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_val("post_rst_busy", {63'd0, bus.Busy}, 64'd0);
        check_val("post_rst_hi", {32'd0, bus.Hi}, 64'd0);
        check_val("post_rst_lo", {32'd0, bus.Lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: Busy cycles for div/divu.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1: one-cycle issue pulse from the E stage.
REQ-006 SHALL have port Op, input, 3: opcode sampled with Start: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-007 SHALL have port A, input, 32: E-stage forwarded rs operand.
REQ-008 SHALL have port B, input, 32: E-stage forwarded rt operand.
REQ-009 SHALL have port MdUseD, input, 1: D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port Busy, output, 1: a mult/div operation is in flight.
REQ-011 SHALL have port StallMD, output, 1: D-stage stall request to the hazard unit.
REQ-012 SHALL have port Hi, output, 32: architectural HI register.
REQ-013 SHALL have port Lo, output, 32: architectural LO register.

Function
REQ-014 SHALL implement FSM states IDLE and RUN plus a 4-bit down counter Cnt.
REQ-015 SHALL, in IDLE with Start and Op in 0-3, latch the pending result into shadow registers HiS/LoS, load Cnt with MULT_CYCLES-1 or DIV_CYCLES-1 and enter RUN.
REQ-016 SHALL compute mult as signed 64-bit A*B and multu as unsigned 64-bit A*B, with HiS = bits 63:32 and LoS = bits 31:0.
REQ-017 SHALL compute div/divu with LoS = quotient and HiS = remainder, signed ops truncating toward zero and the remainder taking the sign of A.
REQ-018 SHALL, for div/divu with B = 0, still run DIV_CYCLES cycles and leave Hi/Lo unchanged at completion.
REQ-019 SHALL assert Busy exactly while in RUN, i.e. from the cycle after Start for MULT_CYCLES or DIV_CYCLES cycles.
REQ-020 SHALL decrement Cnt each RUN cycle; when Cnt = 0, copy HiS/LoS into Hi/Lo at that edge and return to IDLE.
REQ-021 SHALL make the new Hi/Lo visible in the first cycle Busy is low.
REQ-022 SHALL, on Start with Op 4 (mthi), write A into Hi at that edge; with Op 5 (mtlo), write A into Lo; neither sets Busy.
REQ-023 SHALL ignore Start with Op 6-7.
REQ-024 SHALL ignore Start while in RUN; in-flight state and results are unaffected. The hazard unit guarantees this never occurs, and the bench asserts it.
REQ-025 SHALL drive StallMD = MdUseD & (Busy | Start) combinationally.
REQ-026 SHALL, on back-to-back mult/div, accept a new Start in the first IDLE cycle after completion.

Reset
REQ-027 SHALL, on Reset high, immediately (asynchronously) force state IDLE, Cnt = 0, Busy = 0, Hi = Lo = HiS = LoS = 0.
REQ-028 SHALL, on reset mid-operation, discard the pending result; Hi/Lo remain 0.
REQ-029 SHALL ignore Start in any cycle in which Reset is high.
REQ-030 SHALL drive StallMD = 0 while Reset is high.

Verification
REQ-031 SHALL cover: mult with A = 0xFFFFFFFF, B = 2 -> Busy high 5 cycles; then Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFE.
REQ-032 SHALL cover: multu with A = 0xFFFFFFFF, B = 2 -> Hi = 0x00000001, Lo = 0xFFFFFFFE after 5 Busy cycles.
REQ-033 SHALL cover: div with A = -7, B = 2 -> Busy high 10 cycles; then Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; divu with B = 0 -> Hi/Lo unchanged.
REQ-034 SHALL cover: MdUseD = 1 held during Start plus 5 Busy cycles -> StallMD = 1 for exactly 6 cycles, then 0.
REQ-035 SHALL cover: mthi with A = 0x12345678 in IDLE -> Hi = 0x12345678 next cycle, Busy stays 0.
REQ-036 SHALL cover: Reset pulse at cycle 3 of a div -> Busy drops without waiting for a clock edge; Hi = Lo = 0; no commit occurs later.
